// File: rtl/sprite_store_scan.sv
// sprite_store_scan
//   Per-line sprite selection. During SCAN, OAM entries are streamed in and
//   those whose Y range covers the current line are captured into up to
//   N_SLOTS slots in arrival order. During RENDER, each presented pixel X is
//   compared against all live slots. The lowest-numbered hit is registered
//   as a fetch request. sprite_done retires the reported slot.
//
// Ports
//   clk1         sole clock, rising edge
//   reset_video  synchronous active-high reset
//   scan_start   pulse: begin a new scan (wins over everything but reset)
//   oam_valid    oam_y / oam_x / oam_idx valid this cycle
//   oam_y/x/idx  OAM entry fields
//   v            current line number
//   tall         sprite height mode (0 = 8 lines, 1 = 16), latched at scan_start
//   px/px_valid  current pixel X position
//   sprite_done  retire the slot reported by match_slot
//   line_end     end the render phase
//   scanning     FSM in SCAN
//   rendering    FSM in RENDER
//   count/full   slots filled, count == N_SLOTS
//   match*       registered fetch request (slot, OAM index, sprite line)
module sprite_store_scan #(
    parameter int N_SLOTS  = 10,
    parameter int N_OAM    = 40,
    parameter int Y_OFFSET = 16
) (
    input  logic       clk1,
    input  logic       reset_video,
    input  logic       scan_start,
    input  logic       oam_valid,
    input  logic [7:0] oam_y,
    input  logic [7:0] oam_x,
    input  logic [5:0] oam_idx,
    input  logic [7:0] v,
    input  logic       tall,
    input  logic [7:0] px,
    input  logic       px_valid,
    input  logic       sprite_done,
    input  logic       line_end,
    output logic       scanning,
    output logic       rendering,
    output logic [4:0] count,
    output logic       full,
    output logic       match,
    output logic [3:0] match_slot,
    output logic [5:0] match_idx,
    output logic [3:0] match_line
);

    typedef enum logic [1:0] {IDLE, SCAN, RENDER} state_t;

    localparam logic [7:0] Y_OFF8 = 8'(Y_OFFSET);
    localparam logic [4:0] SLOTS5 = 5'(N_SLOTS);
    localparam logic [6:0] OAM7   = 7'(N_OAM);

    state_t             state;
    logic [N_SLOTS-1:0] slot_valid;
    logic [7:0]         slot_x    [N_SLOTS];
    logic [5:0]         slot_idx  [N_SLOTS];
    logic [3:0]         slot_line [N_SLOTS];
    logic [5:0]         entry_cnt;
    logic               tall_q;

    logic [7:0]         line_w;
    logic               in_range;
    logic [6:0]         entry_next;
    logic [N_SLOTS-1:0] retire;
    logic [N_SLOTS-1:0] live;
    logic               hit;
    logic [3:0]         win_slot;
    logic [5:0]         win_idx;
    logic [3:0]         win_line;

    assign scanning  = (state == SCAN);
    assign rendering = (state == RENDER);
    assign full      = (count == SLOTS5);

    // Mod-256 distance from the sprite's top edge to the current line.
    assign line_w     = v + Y_OFF8 - oam_y;
    assign in_range   = tall_q ? (line_w < 8'd16) : (line_w < 8'd8);
    // One bit wider than the entry counter so N_OAM = 64 is reachable.
    assign entry_next = {1'b0, entry_cnt} + 7'd1;

    // The slot being retired is masked out of this edge's search so the
    // registered request moves straight to the next-priority slot.
    always_comb begin
        retire = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            retire[i] = sprite_done && match && (match_slot == 4'(i));
        end
        live = slot_valid & ~retire;
    end

    // Priority search: lowest-numbered live slot with an exact X match.
    always_comb begin
        hit      = 1'b0;
        win_slot = '0;
        win_idx  = '0;
        win_line = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (!hit && live[i] && (slot_x[i] == px)) begin
                hit      = 1'b1;
                win_slot = 4'(i);
                win_idx  = slot_idx[i];
                win_line = slot_line[i];
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (reset_video) begin
            state      <= IDLE;
            slot_valid <= '0;
            count      <= '0;
            entry_cnt  <= '0;
            tall_q     <= 1'b0;
            match      <= 1'b0;
            match_slot <= '0;
            match_idx  <= '0;
            match_line <= '0;
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                slot_x[i]    <= '0;
                slot_idx[i]  <= '0;
                slot_line[i] <= '0;
            end
        end else if (scan_start) begin
            state      <= SCAN;
            slot_valid <= '0;
            count      <= '0;
            entry_cnt  <= '0;
            tall_q     <= tall;
            match      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    match <= 1'b0;
                end
                SCAN: begin
                    match <= 1'b0;
                    if (oam_valid) begin
                        entry_cnt <= entry_next[5:0];
                        if (entry_next == OAM7) begin
                            state <= RENDER;
                        end
                        if (in_range && !full) begin
                            count <= count + 5'd1;
                            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                                if (count == 5'(i)) begin
                                    slot_valid[i] <= 1'b1;
                                    slot_x[i]     <= oam_x;
                                    slot_idx[i]   <= oam_idx;
                                    slot_line[i]  <= line_w[3:0];
                                end
                            end
                        end
                    end
                end
                RENDER: begin
                    if (line_end) begin
                        state      <= IDLE;
                        slot_valid <= '0;
                        match      <= 1'b0;
                    end else begin
                        slot_valid <= live;
                        if (px_valid && hit) begin
                            match      <= 1'b1;
                            match_slot <= win_slot;
                            match_idx  <= win_idx;
                            match_line <= win_line;
                        end else begin
                            match <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    match <= 1'b0;
                end
            endcase
        end
    end

endmodule
